// File: rtl/wb_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_if
// Bundles the signals between the write-port arbiter and its surroundings:
//   - Wb*      : writeback-stage write request and its accept
//   - Md*      : multi-cycle unit result offer and its ready
//   - Reg*     : register file write port
//   - StallOut : writeback hold request
//   - Rs/Rt*   : decode-stage source registers and their pending flags
// Modport "slave" is the arbiter; modport "master" is the pipeline side.
// -----------------------------------------------------------------------------
interface wb_port_arbiter_if;
    logic        WbValidIn;
    logic [4:0]  WbRegIn;
    logic [31:0] WbDataIn;
    logic        WbAcceptOut;

    logic        MdValidIn;
    logic [4:0]  MdRegIn;
    logic [31:0] MdDataIn;
    logic        MdReadyOut;

    logic        RegWriteOut;
    logic [4:0]  RegAddrOut;
    logic [31:0] RegDataOut;

    logic        StallOut;

    logic [4:0]  RsIn;
    logic [4:0]  RtIn;
    logic        RsPendingOut;
    logic        RtPendingOut;

    modport master (
        output WbValidIn, WbRegIn, WbDataIn,
        input  WbAcceptOut,
        output MdValidIn, MdRegIn, MdDataIn,
        input  MdReadyOut,
        input  RegWriteOut, RegAddrOut, RegDataOut,
        input  StallOut,
        output RsIn, RtIn,
        input  RsPendingOut, RtPendingOut
    );

    modport slave (
        input  WbValidIn, WbRegIn, WbDataIn,
        output WbAcceptOut,
        input  MdValidIn, MdRegIn, MdDataIn,
        output MdReadyOut,
        output RegWriteOut, RegAddrOut, RegDataOut,
        output StallOut,
        input  RsIn, RtIn,
        output RsPendingOut, RtPendingOut
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the register file write port between the writeback stage and results
// from the multi-cycle (mul/div) unit. Multi-cycle results are buffered in a
// small FIFO and written in idle writeback slots; a starvation counter forces a
// one-cycle writeback stall so buffered results always retire. Pending flags
// let the decode hazard logic stall on registers still waiting in the FIFO.
//
// Ports:
//   clk   : single clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : wb_port_arbiter_if.slave (writeback, multi-cycle, write port,
//           stall and pending signals)
// Parameters:
//   DEPTH        : FIFO entries, power of two in 2..16
//   STARVE_LIMIT : denied cycles before StallOut asserts, 1..15
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    localparam int          AW            = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO      = (AW+1)'(0);
    localparam logic [AW:0] CNT_ONE       = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ZERO    = AW'(0);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [3:0]  STARVE_THRESH = 4'(STARVE_LIMIT);
    localparam logic [3:0]  STARVE_MAX    = 4'd15;

    // FIFO storage and bookkeeping
    logic [4:0]    reg_mem_r  [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;
    logic [3:0]    starve_r;

    logic          full_s;
    logic          empty_s;
    logic          stall_s;
    logic          md_ready_s;
    logic          push_s;
    logic          pop_s;

    logic          wb_accept_s;
    logic          reg_write_s;
    logic [4:0]    reg_addr_s;
    logic [31:0]   reg_data_s;

    logic          rs_pending_s;
    logic          rt_pending_s;
    logic [AW-1:0] slot_s;

    assign full_s     = (count_r == FULL_COUNT);
    assign empty_s    = (count_r == CNT_ZERO);
    assign stall_s    = (starve_r >= STARVE_THRESH);
    assign md_ready_s = ~full_s & ~reset;
    // Results for r0 are handshaken but never stored.
    assign push_s     = bus.MdValidIn & md_ready_s & (bus.MdRegIn != 5'd0);

    // Write-port grant: forced FIFO drain, then writeback, then idle-slot drain
    always_comb begin
        pop_s       = 1'b0;
        wb_accept_s = 1'b0;
        reg_write_s = 1'b0;
        reg_addr_s  = 5'd0;
        reg_data_s  = 32'd0;
        if (reset) begin
            pop_s       = 1'b0;
        end else if (stall_s && !empty_s) begin
            pop_s       = 1'b1;
            reg_write_s = 1'b1;
            reg_addr_s  = reg_mem_r[rd_ptr_r];
            reg_data_s  = data_mem_r[rd_ptr_r];
        end else if (bus.WbValidIn && !stall_s) begin
            wb_accept_s = 1'b1;
            reg_write_s = (bus.WbRegIn != 5'd0);
            reg_addr_s  = bus.WbRegIn;
            reg_data_s  = bus.WbDataIn;
        end else if (!empty_s) begin
            pop_s       = 1'b1;
            reg_write_s = 1'b1;
            reg_addr_s  = reg_mem_r[rd_ptr_r];
            reg_data_s  = data_mem_r[rd_ptr_r];
        end else begin
            reg_write_s = 1'b0;
        end
    end

    // Pending flags: compare sources against every occupied FIFO slot
    always_comb begin
        rs_pending_s = 1'b0;
        rt_pending_s = 1'b0;
        slot_s       = PTR_ZERO;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s       = rd_ptr_r + AW'(i);
            rs_pending_s = rs_pending_s | (((AW+1)'(i) < count_r) &&
                           (reg_mem_r[slot_s] == bus.RsIn) && (bus.RsIn != 5'd0));
            rt_pending_s = rt_pending_s | (((AW+1)'(i) < count_r) &&
                           (reg_mem_r[slot_s] == bus.RtIn) && (bus.RtIn != 5'd0));
        end
    end

    // FIFO payload storage; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (push_s) begin
            reg_mem_r[wr_ptr_r]  <= bus.MdRegIn;
            data_mem_r[wr_ptr_r] <= bus.MdDataIn;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: counts cycles a nonempty FIFO goes without a pop
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_r <= 4'd0;
        end else if (pop_s || empty_s) begin
            starve_r <= 4'd0;
        end else if (starve_r != STARVE_MAX) begin
            starve_r <= starve_r + 4'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    assign bus.WbAcceptOut  = wb_accept_s;
    assign bus.MdReadyOut   = md_ready_s;
    assign bus.RegWriteOut  = reg_write_s;
    assign bus.RegAddrOut   = reg_addr_s;
    assign bus.RegDataOut   = reg_data_s;
    assign bus.StallOut     = stall_s;
    assign bus.RsPendingOut = rs_pending_s;
    assign bus.RtPendingOut = rt_pending_s;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the pipeline writeback stage (already muxed by the writeback data selector) and results returned by a multi-cycle execution unit (multiply/divide). Multi-cycle results are buffered in a small FIFO and drained into idle writeback slots. A starvation counter forces a one-cycle writeback stall so buffered results always retire. The block also reports per-operand pending status so the decode-stage hazard logic can stall on buffered destinations.

## Interface
Parameters:
- DEPTH, 4: result FIFO entries; must be a power of two, 2..16.
- STARVE_LIMIT, 3: consecutive denied cycles of a nonempty FIFO before StallOut asserts; range 1..15.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- WbValidIn  input  1  writeback stage requests a register write this cycle.
- WbRegIn  input  5  writeback destination register.
- WbDataIn  input  32  writeback data (writeback data-select output).
- WbAcceptOut  output  1  writeback request consumed this cycle.
- MdValidIn  input  1  multi-cycle unit offers a result.
- MdRegIn  input  5  result destination register.
- MdDataIn  input  32  result data.
- MdReadyOut  output  1  FIFO can accept; transfer when MdValidIn & MdReadyOut.
- RegWriteOut  output  1  register file write enable.
- RegAddrOut  output  5  register file write address.
- RegDataOut  output  32  register file write data.
- StallOut  output  1  writeback stage must hold its instruction this cycle.
- RsIn, RtIn  input  5 each  decode-stage source registers.
- RsPendingOut, RtPendingOut  output  1 each  source matches a buffered FIFO destination.

## Operation
- FIFO: DEPTH entries of {reg[4:0], data[31:0]}, read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Push: when MdValidIn & MdReadyOut, the entry is written at the tail. Entries with MdRegIn==0 are dropped: MdReadyOut stays high and nothing is stored.
- MdReadyOut = ~full & ~reset. A push while full is not allowed, even when a pop occurs in the same cycle.
- Write-port grant is combinational from current state and inputs. Priority order:
  1. If StallOut=1 and the FIFO is nonempty: pop the head and write it. WbAcceptOut=0; the pipeline re-presents the same writeback next cycle.
  2. Else if WbValidIn: WbAcceptOut=1. RegWriteOut=(WbRegIn!=0), with address and data taken from the Wb inputs.
  3. Else if the FIFO is nonempty: pop the head and write it.
  4. Else: RegWriteOut=0.
- WbAcceptOut = WbValidIn & ~StallOut.
- Starvation counter (4 bits):
  - Cleared on a pop or when the FIFO is empty.
  - Otherwise increments, saturating at 15.
  - StallOut = (counter >= STARVE_LIMIT), decoded from the register.
- Pending flags:
  - RsPendingOut is set when any stored FIFO entry has reg==RsIn and RsIn!=0; RtPendingOut likewise for RtIn.
  - Only stored entries are checked. An entry being pushed counts from the next cycle. An entry being popped stops counting from the next cycle.
- When idle, RegAddrOut and RegDataOut are 0.

## Timing
- Reset (synchronous): FIFO empty, pointers 0, counter 0. Consequently StallOut=0, Rs/RtPendingOut=0 and MdReadyOut=1 from the first cycle after reset.
- While reset is high, RegWriteOut=0, WbAcceptOut=0 and MdReadyOut=0. Reset asserted mid-operation discards all buffered results.
- Writeback path latency: 0 cycles (combinational pass-through to the write port).
- FIFO path latency: a result pushed in cycle N is writable no earlier than cycle N+1.
- Simultaneous push and pop on a nonempty, non-full FIFO: count unchanged and both pointers advance.
- Push into an empty FIFO while WbValidIn=0: the entry is written in cycle N+1, not cycle N.
- Worst-case buffered-result wait with continuous WbValidIn: STARVE_LIMIT cycles of denial, then a stall cycle that pops exactly one entry. The counter then restarts at 0.
- Writes to register 0 never assert RegWriteOut.

## Test plan
- Reset, then idle: RegWriteOut=0, MdReadyOut=1, StallOut=0. Then WbValidIn=1, WbRegIn=8, WbDataIn=0x1234 -> same cycle RegWriteOut=1, RegAddrOut=8, RegDataOut=0x1234, WbAcceptOut=1.
- Push result {reg 5, 0xDEADBEEF} in cycle N with no Wb traffic:
  - RsIn=5 -> RsPendingOut=1 in N+1.
  - Write of reg 5 = 0xDEADBEEF in N+1.
  - RsPendingOut=0 in N+2.
- Continuous WbValidIn, one buffered entry, STARVE_LIMIT=3: denied for 3 cycles, then StallOut=1 and WbAcceptOut=0 on the 4th cycle. The FIFO entry is written, and the held Wb write lands the following cycle.
- Fill 4 entries with Wb busy: MdReadyOut=0 while full. Drain in order: regs 1,2,3,4 appear in push order. After pointer wrap, push 2 more and confirm order is preserved.
- Push to reg 0 and Wb write to reg 0: RegWriteOut never asserts, the FIFO count stays unchanged, and RsIn=0 gives RsPendingOut=0.
- Assert reset with 3 buffered entries: from the next cycle the FIFO is empty, pending flags are 0 and no buffered write occurs.
